// File: rtl/d16_mem_arb.sv
// d16_mem_arb: shares one single-port RAM between the d16 CPU and a secondary master.
// Latency: CPU path is combinational (zero added cycles); secondary request to ack is >= 2 cycles.
// Backpressure: the CPU always wins; the secondary request waits in PEND, with o_s_busy high, until the CPU leaves cyc low.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_cpu_*, o_cpu_dat      CPU bus; read data is a combinational copy of i_mem_dat
//   i_s_*, o_s_busy/ack/dat secondary request/acknowledge port, read data registered
//   o_mem_*, i_mem_dat      shared RAM port (asynchronous read data)
//   o_starve                sticky flag, raised when the secondary waits WAIT_MAX cycles
// Optional feature: define D16_ARB_WATCHDOG_EN to build the starvation watchdog.
module d16_mem_arb #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_MAX = 255
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic          i_cpu_cyc,
  input  logic          i_cpu_we,
  input  logic [DW-1:0] i_cpu_dat,
  output logic [DW-1:0] o_cpu_dat,
  input  logic          i_s_req,
  input  logic          i_s_we,
  input  logic [AW-1:0] i_s_addr,
  input  logic [DW-1:0] i_s_dat,
  output logic          o_s_busy,
  output logic          o_s_ack,
  output logic [DW-1:0] o_s_dat,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_cyc,
  output logic          o_mem_we,
  output logic [DW-1:0] o_mem_dat,
  input  logic [DW-1:0] i_mem_dat,
  output logic          o_starve
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dat;
  logic [DW-1:0] r_s_dat;
  logic          w_gnt_s;

  // Grant is also blocked during reset so a pending request is dropped
  // rather than performed in the very cycle it is being cleared.
  assign w_gnt_s = (r_state == PEND) && !i_cpu_cyc && !i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_s_dat <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_s_req) begin
            r_we    <= i_s_we;
            r_addr  <= i_s_addr;
            r_dat   <= i_s_dat;
            r_state <= PEND;
          end
        end
        PEND: begin
          if (w_gnt_s) begin
            // Writes leave the last read data untouched.
            if (!r_we) r_s_dat <= i_mem_dat;
            r_state <= ACK;
          end
        end
        ACK:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_s_busy  = (r_state != IDLE);
  assign o_s_ack   = (r_state == ACK);
  assign o_s_dat   = r_s_dat;
  assign o_cpu_dat = i_mem_dat;

  // CPU has absolute priority; when nobody owns the bus, address and data
  // still follow the CPU so the idle bus looks like the CPU-only system.
  always_comb begin
    o_mem_addr = i_cpu_addr;
    o_mem_dat  = i_cpu_dat;
    o_mem_cyc  = 1'b0;
    o_mem_we   = 1'b0;
    if (i_cpu_cyc) begin
      o_mem_cyc = 1'b1;
      o_mem_we  = i_cpu_we;
    end else if (w_gnt_s) begin
      o_mem_addr = r_addr;
      o_mem_dat  = r_dat;
      o_mem_cyc  = 1'b1;
      o_mem_we   = r_we;
    end
  end

`ifdef D16_ARB_WATCHDOG_EN
  localparam int            CW   = (WAIT_MAX < 256) ? 8 : 16;
  localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

  logic [CW-1:0] r_cnt;
  logic          r_starve;

  // Counts PEND cycles lost to the CPU. The flag is raised on the same edge
  // the count reaches WMAX, so it is visible right after the WMAX-th lost cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else begin
      if (r_state == IDLE && i_s_req) begin
        r_cnt <= '0;
      end else if (r_state == PEND && !w_gnt_s && r_cnt != WMAX) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt + 1'b1 == WMAX) r_starve <= 1'b1;
      end
    end
  end

  assign o_starve = r_starve;
`else
  // No watchdog: WAIT_MAX stays in the parameter list for a uniform
  // interface and is only referenced so it is not flagged as dead.
  assign o_starve = (WAIT_MAX < 0);
`endif

endmodule

// File: doc/d16_mem_arb.md
# d16_mem_arb

Single-port memory arbiter between the d16 CPU Wishbone-style bus and one secondary requester, e.g. a program loader, debug port or DMA engine. The CPU cannot stall and expects same-cycle read data, so it always wins. The secondary port is served only in cycles where the CPU leaves `cyc` low, using a registered request/acknowledge handshake. The block sits between the CPU, the secondary master and the shared RAM.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width
- `WAIT_MAX`, 255, watchdog threshold in cycles (used only with the watchdog compiled in)

Ports:
- `i_clk`  in  1  clock
- `i_reset`  in  1  reset, synchronous, active-high
- `i_cpu_addr`  in  AW  CPU address
- `i_cpu_cyc`  in  1  CPU cycle valid
- `i_cpu_we`  in  1  CPU write enable
- `i_cpu_dat`  in  DW  CPU write data
- `o_cpu_dat`  out  DW  CPU read data; combinational copy of `i_mem_dat`
- `i_s_req`  in  1  secondary request; sampled only in IDLE
- `i_s_we`  in  1  secondary write enable
- `i_s_addr`  in  AW  secondary address
- `i_s_dat`  in  DW  secondary write data
- `o_s_busy`  out  1  request held (PEND or ACK)
- `o_s_ack`  out  1  one-cycle completion pulse
- `o_s_dat`  out  DW  registered read data; valid while `o_s_ack`=1 and held until the next read completes
- `o_mem_addr`  out  AW  memory address
- `o_mem_cyc`  out  1  memory cycle valid
- `o_mem_we`  out  1  memory write enable
- `o_mem_dat`  out  DW  memory write data
- `i_mem_dat`  in  DW  memory read data, asynchronous
- `o_starve`  out  1  sticky watchdog flag

## Operation
- States: IDLE, PEND, ACK. Reset value is IDLE.
- **IDLE**
  - If `i_s_req`=1: latch `i_s_we`, `i_s_addr` and `i_s_dat` into request registers, then go to PEND.
  - Otherwise stay in IDLE.
- **PEND**
  - Secondary grant is combinational: `gnt_s = (state==PEND) && !i_cpu_cyc`.
  - If `gnt_s`: drive memory from the request registers with `o_mem_cyc`=1 and `o_mem_we` = latched we. On a read, latch `i_mem_dat` into `o_s_dat` at the clock edge. Go to ACK.
  - Else stay in PEND. Request registers do not change.
- **ACK**
  - `o_s_ack`=1 for exactly one cycle, then go to IDLE.
  - `i_s_req` is ignored in ACK. It is next sampled in IDLE.
- **Memory mux**
  - `i_cpu_cyc`=1: memory takes the CPU addr, we, dat and cyc. The CPU wins even in PEND.
  - `gnt_s`=1: memory takes the secondary request registers.
  - Neither: `o_mem_cyc`=0, `o_mem_we`=0, address and data follow the CPU inputs.
- `o_mem_we` is never 1 while `o_mem_cyc`=0.
- A secondary write never changes `o_s_dat`.
- `i_s_*` changes while `o_s_busy`=1 have no effect.
- Simultaneous CPU request and PEND: CPU is served, secondary waits with no loss.
- Reset mid-PEND or mid-ACK: the request is dropped (not performed if not yet granted), and the ack is suppressed.

## Timing
- Reset values:
  - `o_s_busy`=0, `o_s_ack`=0, `o_s_dat`=0, `o_starve`=0.
  - `o_mem_cyc`/`o_mem_we` follow `i_cpu_cyc`/`i_cpu_we` (no CPU activity during reset gives 0).
- CPU path: zero added latency, purely combinational.
- Secondary minimum latency is 2 cycles from request to ack:
  - `i_s_req` is sampled at edge N.
  - Memory access happens in cycle N+1 if the CPU is idle.
  - `o_s_ack` is high in cycle N+2.
  - Each extra CPU-busy cycle in PEND adds 1.
- Maximum secondary throughput is one access per 3 cycles, with `i_s_req` held continuously.
- With the d16 FETCH/EXECUTE cadence, every EXECUTE cycle without a memory operand is a grant slot. FETCH never is.

## Configuration
- Macro `D16_ARB_WATCHDOG_EN`.
- **Defined:**
  - An 8..16-bit counter clears on entry to PEND and increments each PEND cycle without a grant, saturating at `WAIT_MAX`.
  - When the counter reaches `WAIT_MAX`, `o_starve` sets and stays 1 until `i_reset`.
  - Grant still proceeds normally afterwards.
- **Undefined:** no counter is implemented and `o_starve` is tied to 0.

## Test plan
- **CPU-only traffic:** CPU write `0x1234` to `0x0010`, then read it back → memory sees cyc=1/we=1 then cyc=1/we=0, `o_cpu_dat`=`0x1234` in the same cycle, `o_s_busy` stays 0.
- **Idle CPU, secondary read:** secondary read of `0x0020` (memory holds `0xBEEF`) with CPU idle → mem addr `0x0020` one cycle after req, `o_s_ack` pulses 2 cycles after req with `o_s_dat`=`0xBEEF`.
- **Contention:** secondary write `0x5A5A` to `0x0030` issued while CPU cyc=1 for 3 consecutive cycles → memory keeps CPU addr for those 3 cycles, secondary write occurs in the first CPU-idle cycle, ack 1 cycle later, `o_s_dat` unchanged.
- **Back-to-back:** back-to-back secondary requests with `i_s_req` held high and CPU idle → acks every 3rd cycle; the `i_s_addr` change in PEND is ignored.
- **Reset in PEND:** `i_reset` pulsed while in PEND with CPU busy → no secondary memory cycle, no ack, `o_s_busy`=0 next cycle.
- **Watchdog (with `D16_ARB_WATCHDOG_EN`, `WAIT_MAX`=4):** CPU cyc held high for 6 cycles during PEND → `o_starve`=1 after the 4th waiting cycle, remaining 1 after the eventual ack until reset.
